// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache refill engine.
package cache_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        DONE
    } refill_state_t;

    // Width of the word-within-block index.
    function automatic int idx_w(input int words);
        return $clog2(words);
    endfunction

    // Clears the word-offset bits so the address points at the first word of its block.
    function automatic logic [31:0] block_align(input logic [31:0] addr, input int words);
        logic [31:0] mask;
        mask = 32'(words - 1);
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_mem_wait_timer.sv
// Loadable down-counter that flags the edge at which the memory latency runs out.
module mem_wait_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    // Load on request, otherwise count down to zero and stay there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Refill engine: fetches a whole aligned block from fixed-latency memory and writes it into the cache word by word.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int MEM_LATENCY     = 2,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_last,
    output logic              busy,
    output logic [CNT_W-1:0]  refill_count
);

    localparam int IDX_W   = idx_w(WORDS_PER_BLOCK);
    localparam int TIMER_W = $clog2(MEM_LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    refill_state_t     state, state_next;
    logic [ADDR_W-1:0] base;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              capture;
    logic              advance;
    logic              timer_load;
    logic              expired;

    // Base is block-aligned, so OR-ing in the index never carries into the block number.
    assign mem_addr = base | ADDR_W'(idx);

    mem_wait_timer #(
        .CNT_W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (TIMER_W'(MEM_LATENCY)),
        .expired    (expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        busy       = 1'b0;
        fill_last  = 1'b0;
        timer_load = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (miss_req) begin
                    accept     = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                busy       = 1'b1;
                mem_rd     = 1'b1;
                timer_load = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (expired) begin
                    capture = 1'b1;
                    if (idx != LAST_IDX) begin
                        advance    = 1'b1;
                        state_next = READ;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                busy       = 1'b1;
                fill_last  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Block base, word index, captured fill word and the saturating refill counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base         <= '0;
            idx          <= '0;
            fill_valid   <= 1'b0;
            fill_addr    <= '0;
            fill_data    <= '0;
            refill_count <= '0;
        end else begin
            fill_valid <= capture;
            if (accept) begin
                base <= ADDR_W'(block_align(32'(miss_addr), WORDS_PER_BLOCK));
                idx  <= '0;
            end
            if (capture) begin
                fill_addr <= mem_addr;
                fill_data <= mem_data;
            end
            if (advance) begin
                idx <= idx + IDX_W'(1);
            end
            if (state == DONE && refill_count != '1) begin
                refill_count <= refill_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Refill engine between the cache and the backing memory.
- On a cache miss it fetches the whole aligned block containing the missing address from the synchronous, fixed-latency memory, one word at a time.
- Each word is presented to the cache as a write strobe; the cache turns the pending miss into a hit once the last word is written.
- Also keeps a saturating count of completed refills for performance runs.

Parameters:
- ADDR_W, 15, word address width shared by cache and memory
- DATA_W, 32, data word width
- WORDS_PER_BLOCK, 4, words per cache block; power of two, at least 2
- MEM_LATENCY, 2, cycles from a mem_rd cycle to the edge at which mem_data is valid; at least 1
- CNT_W, 16, width of the refill counter

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- miss_req  input  1  level from cache: current read_address missed
- miss_addr  input  ADDR_W  missing word address (cache read_address)
- mem_rd  output  1  one-cycle memory read strobe
- mem_addr  output  ADDR_W  memory word address
- mem_data  input  DATA_W  memory read data
- fill_valid  output  1  one-cycle cache write strobe
- fill_addr  output  ADDR_W  word address being written
- fill_data  output  DATA_W  word being written
- fill_last  output  1  high with fill_valid on the final word of the block
- busy  output  1  refill in progress
- refill_count  output  CNT_W  completed refills, saturating

Behaviour:
- Reset (asynchronous, any state): state IDLE; all outputs 0, including refill_count. Any refill in flight is abandoned; no fill_valid may appear after reset deasserts.
- States: IDLE, READ, WAIT, DONE. A word index idx of log2(WORDS_PER_BLOCK) bits and a wait counter are internal.
- IDLE:
  - busy=0.
  - If miss_req=1 at the edge: latch base = miss_addr with the low log2(WORDS_PER_BLOCK) bits cleared, set idx=0, go to READ.
  - miss_addr is sampled only at acceptance; later changes are ignored.
- READ:
  - One cycle; mem_rd=1, mem_addr=base+idx.
  - Go to WAIT, with the wait counter loaded to MEM_LATENCY.
- WAIT:
  - mem_rd=0; mem_addr is held.
  - The counter decrements each edge. At the edge where it expires, capture mem_data into fill_data and set fill_addr=base+idx. fill_valid is 1 for the following cycle only.
  - From that same edge: if idx is not the last index, increment idx and go to READ; otherwise go to DONE.
  - The next READ therefore overlaps the previous word's fill cycle.
- DONE:
  - One cycle; fill_valid=1 and fill_last=1.
  - refill_count increments at the exit edge, saturating at all-ones.
  - Go to IDLE. miss_req is ignored in DONE.
- busy = 1 in READ, WAIT and DONE.
- Per-word period is MEM_LATENCY+1 cycles. If acceptance is edge 0, the first fill_valid is in cycle MEM_LATENCY+2.
  - Total busy cycles = WORDS_PER_BLOCK*(MEM_LATENCY+1)+1. Defaults give 13.
- Address arithmetic: base is block-aligned, so base+idx never carries out of the block; the top block (0x7FFC..0x7FFF) needs no special case.
- Back-to-back misses: the earliest new acceptance is the edge ending the first IDLE cycle after DONE.
- A miss_req pulse shorter than one edge sample in IDLE is not seen; the cache holds miss_req until it hits.

Decomposition:
- Shared package cache_pkg:
  - state enum refill_state_t {IDLE, READ, WAIT, DONE}
  - ADDR_W and DATA_W defaults
  - function clog2-based IDX_W
  - block-align helper function
- One sub-module, mem_wait_timer: a loadable down-counter that flags expiry. It keeps latency counting out of the FSM.

Test Plan:
- Reset: hold rst=1 for 3 cycles with miss_req=1 → all outputs 0, no mem_rd. After release, the first mem_rd is on the cycle after the first sampled edge.
- Single miss, miss_addr=0x0402, defaults:
  - mem_rd in cycles 1, 4, 7, 10 with mem_addr 0x0400..0x0403.
  - fill_valid in cycles 4, 7, 10, 13 carrying the memory contents of those addresses.
  - fill_last only in cycle 13; busy cycles 1-13; refill_count=1.
- miss_addr changes to 0x1234 mid-refill → all fill_addr values stay within 0x0400..0x0403.
- MEM_LATENCY=1, WORDS_PER_BLOCK=8, miss_addr=0x7FFB → fills 0x7FF8..0x7FFF every 2 cycles, no wrap to 0x0000, busy for 17 cycles.
- Reset asserted in WAIT of word 2 → outputs clear immediately, no further fill_valid, refill_count unchanged.
- refill_count preset near saturation: run 0xFFFF+2 short refills (or force the count to 0xFFFE) → the count stops at 0xFFFF.
